execute_stage_pipe: RTL and testbench

- Parametrised EX stage for the 5-stage pipeline. Sits between the ID/EX and EX/MEM boundaries.
- Forwards operands, runs the ALU, resolves all branches and JAL/JALR, and owns the EX/MEM output register.
- Uses a valid/ready handshake toward MEM and a registered one-cycle redirect toward IF.
- Squashes the single wrong-path instruction behind a taken redirect.

---
 rtl/execute_stage_pipe.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_execute_stage_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_pipe.sv
// -----------------------------------------------------------------------------
// execute_stage_pipe
//
// EX stage of the 5-stage pipeline, between the ID/EX and EX/MEM boundaries.
// The block forwards operands, runs the ALU, resolves conditional branches
// and JAL/JALR, and owns the EX/MEM output register. Toward MEM it uses a
// valid/ready handshake. Toward IF it issues a registered one-cycle redirect
// pulse. The single wrong-path instruction accepted behind a redirect is
// squashed.
//
// Parameters
//   XLEN      datapath width (32 or 64)
//   REG_AW    register address width
//   RESET_PC  value of pc_new_o during and after reset
//
// Ports
//   clk_i, reset_i             clock, synchronous active-high reset
//   valid_i / ready_o          ID/EX handshake (ready_o = !valid_o || mem_ready_i)
//   pc_i, instruction_i        instruction PC and raw bits (opcode, funct3 used)
//   rs1_data_i, rs2_data_i     register-file read data
//   rs1_i, rs2_i, rd_i         register addresses
//   aluop_i, imm_i             ALU opcode, sign-extended immediate
//   alusrc1_i, alusrc2_i       operand selects (pc_i / imm_i vs forwarded regs)
//   reg_write_i, is_load_i,
//   is_store_i                 control flags carried into EX/MEM
//   wb_we_i, wb_rd_i, wb_data_i  WB-stage forwarding source
//   mem_ready_i                MEM accepts the EX/MEM contents
//   valid_o, alu_result_o, store_data_o, rd_o,
//   reg_write_o, is_load_o, is_store_o   EX/MEM register
//   pc_new_o, pc_select_o      redirect target and one-cycle redirect pulse
//
// Optional feature (macro EXEC_MISALIGN_TRAP_EN)
//   Adds trap_o / trap_pc_o. A taken target whose low two bits are not zero
//   raises a one-cycle trap_o pulse with trap_pc_o = pc_i instead of a
//   redirect, and the instruction is registered with reg_write_o = 0.
//   Without the macro, a misaligned target redirects normally.
// -----------------------------------------------------------------------------
module execute_stage_pipe #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           REG_AW   = 5,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // ID/EX side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       instruction_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [5:0]        aluop_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              alusrc1_i,
  input  logic              alusrc2_i,
  input  logic              reg_write_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  // WB forwarding source
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  // EX/MEM side
  input  logic              mem_ready_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              reg_write_o,
  output logic              is_load_o,
  output logic              is_store_o,
  // Redirect toward IF
  output logic [XLEN-1:0]   pc_new_o,
  output logic              pc_select_o
`ifdef EXEC_MISALIGN_TRAP_EN
  ,
  output logic              trap_o,
  output logic [XLEN-1:0]   trap_pc_o
`endif
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_SLL  = 6'd2,
    ALU_SLT  = 6'd3,
    ALU_SLTU = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_OR   = 6'd8,
    ALU_AND  = 6'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign ready_o = !valid_o || mem_ready_i;
  assign accept  = valid_i && ready_o;

  // ---------------------------------------------------------------------------
  // Instruction decode (only opcode and funct3 matter here)
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;
  logic       unused_instr_bits;

  assign opcode            = instruction_i[6:0];
  assign funct3            = instruction_i[14:12];
  assign is_branch         = (opcode == OPC_BRANCH);
  assign is_jal            = (opcode == OPC_JAL);
  assign is_jalr           = (opcode == OPC_JALR);
  assign unused_instr_bits = ^{instruction_i[31:15], instruction_i[11:7]};

  // ---------------------------------------------------------------------------
  // Operand forwarding. The EX/MEM entry is the youngest producer, so it wins
  // over WB. A load in EX/MEM has no data yet; the hazard unit stalls that
  // case, so it is simply not a forwarding source. x0 is never forwarded.
  // ---------------------------------------------------------------------------
  logic exmem_fwd_ok;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign exmem_fwd_ok = valid_o && reg_write_o && !is_load_o;

  function automatic logic [XLEN-1:0] forward_sel(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data,
    input logic              exmem_ok,
    input logic [REG_AW-1:0] exmem_rd,
    input logic [XLEN-1:0]   exmem_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data
  );
    logic [XLEN-1:0] sel;
    sel = rf_data;
    if (rs != '0) begin
      if (exmem_ok && (exmem_rd == rs)) begin
        sel = exmem_data;
      end else if (wb_we && (wb_rd == rs)) begin
        sel = wb_data;
      end
    end
    return sel;
  endfunction

  assign fwd_rs1 = forward_sel(rs1_i, rs1_data_i, exmem_fwd_ok, rd_o, alu_result_o,
                               wb_we_i, wb_rd_i, wb_data_i);
  assign fwd_rs2 = forward_sel(rs2_i, rs2_data_i, exmem_fwd_ok, rd_o, alu_result_o,
                               wb_we_i, wb_rd_i, wb_data_i);

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]    op1;
  logic [XLEN-1:0]    op2;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_out;

  assign op1   = alusrc1_i ? pc_i  : fwd_rs1;
  assign op2   = alusrc2_i ? imm_i : fwd_rs2;
  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned and no latch is inferred.
    alu_out = '0;
    case (aluop_i)
      ALU_ADD:  alu_out = op1 + op2;
      ALU_SUB:  alu_out = op1 - op2;
      ALU_SLL:  alu_out = op1 << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  alu_out = op1 ^ op2;
      ALU_SRL:  alu_out = op1 >> shamt;
      ALU_SRA:  alu_out = $signed(op1) >>> shamt;
      ALU_OR:   alu_out = op1 | op2;
      ALU_AND:  alu_out = op1 & op2;
      default:  alu_out = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch / jump resolution. Branch conditions compare the forwarded
  // registers directly, so the ALU operand selects do not affect them.
  // ---------------------------------------------------------------------------
  logic            br_taken;
  logic            redirect;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] ex_result;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      BR_EQ:   br_taken = (fwd_rs1 == fwd_rs2);
      BR_NE:   br_taken = (fwd_rs1 != fwd_rs2);
      BR_LT:   br_taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      BR_GE:   br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      BR_LTU:  br_taken = (fwd_rs1 <  fwd_rs2);
      BR_GEU:  br_taken = (fwd_rs1 >= fwd_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum  = fwd_rs1 + imm_i;
  assign target    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_i + imm_i);
  assign redirect  = (is_branch && br_taken) || is_jal || is_jalr;
  assign link_addr = pc_i + XLEN'(4);
  assign ex_result = (is_jal || is_jalr) ? link_addr : alu_out;

  // Split the taken case into a real redirect and, when enabled, a trap.
  logic take_redirect;
  logic take_trap;

`ifdef EXEC_MISALIGN_TRAP_EN
  assign take_trap     = redirect && (target[1:0] != 2'b00);
  assign take_redirect = redirect && !take_trap;
`else
  assign take_trap     = 1'b0;
  assign take_redirect = redirect;
`endif

  // ---------------------------------------------------------------------------
  // EX/MEM register and redirect register
  // ---------------------------------------------------------------------------
  // An instruction accepted while pc_select_o is high is the wrong-path
  // fetch behind the redirect: it is registered as a bubble and cannot
  // redirect or trap.
  logic shadow;
  assign shadow = pc_select_o;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o      <= 1'b0;
      alu_result_o <= '0;
      store_data_o <= '0;
      rd_o         <= '0;
      reg_write_o  <= 1'b0;
      is_load_o    <= 1'b0;
      is_store_o   <= 1'b0;
      pc_new_o     <= RESET_PC;
      pc_select_o  <= 1'b0;
`ifdef EXEC_MISALIGN_TRAP_EN
      trap_o       <= 1'b0;
      trap_pc_o    <= '0;
`endif
    end else begin
      // Redirect and trap are single-cycle pulses.
      pc_select_o <= 1'b0;
`ifdef EXEC_MISALIGN_TRAP_EN
      trap_o      <= 1'b0;
`endif
      if (accept) begin
        alu_result_o <= ex_result;
        store_data_o <= fwd_rs2;
        rd_o         <= rd_i;
        if (shadow) begin
          valid_o     <= 1'b0;
          reg_write_o <= 1'b0;
          is_load_o   <= 1'b0;
          is_store_o  <= 1'b0;
        end else begin
          valid_o     <= 1'b1;
          reg_write_o <= reg_write_i && !is_branch && !take_trap;
          is_load_o   <= is_load_i;
          is_store_o  <= is_store_i;
          if (take_redirect) begin
            pc_new_o    <= target;
            pc_select_o <= 1'b1;
          end
`ifdef EXEC_MISALIGN_TRAP_EN
          if (take_trap) begin
            trap_o    <= 1'b1;
            trap_pc_o <= pc_i;
          end
`endif
        end
      end else if (mem_ready_i) begin
        // MEM drained the entry and nothing new arrived.
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
module tb_execute_stage_pipe;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     REG_AW   = 5;
  localparam logic [31:0]     RESET_PC = 32'h0000_0800;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              valid_i;
  logic              ready_o;
  logic [XLEN-1:0]   pc_i;
  logic [31:0]       instruction_i;
  logic [XLEN-1:0]   rs1_data_i, rs2_data_i;
  logic [REG_AW-1:0] rs1_i, rs2_i, rd_i;
  logic [5:0]        aluop_i;
  logic [XLEN-1:0]   imm_i;
  logic              alusrc1_i, alusrc2_i;
  logic              reg_write_i, is_load_i, is_store_i;
  logic              wb_we_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic [XLEN-1:0]   wb_data_i;
  logic              mem_ready_i;
  logic              valid_o;
  logic [XLEN-1:0]   alu_result_o, store_data_o;
  logic [REG_AW-1:0] rd_o;
  logic              reg_write_o, is_load_o, is_store_o;
  logic [XLEN-1:0]   pc_new_o;
  logic              pc_select_o;
`ifdef EXEC_MISALIGN_TRAP_EN
  logic              trap_o;
  logic [XLEN-1:0]   trap_pc_o;
`endif

  int checks = 0;
  int errors = 0;

  execute_stage_pipe #(
    .XLEN     (XLEN),
    .REG_AW   (REG_AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .pc_i          (pc_i),
    .instruction_i (instruction_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rd_i          (rd_i),
    .aluop_i       (aluop_i),
    .imm_i         (imm_i),
    .alusrc1_i     (alusrc1_i),
    .alusrc2_i     (alusrc2_i),
    .reg_write_i   (reg_write_i),
    .is_load_i     (is_load_i),
    .is_store_i    (is_store_i),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .mem_ready_i   (mem_ready_i),
    .valid_o       (valid_o),
    .alu_result_o  (alu_result_o),
    .store_data_o  (store_data_o),
    .rd_o          (rd_o),
    .reg_write_o   (reg_write_o),
    .is_load_o     (is_load_o),
    .is_store_o    (is_store_o),
    .pc_new_o      (pc_new_o),
    .pc_select_o   (pc_select_o)
`ifdef EXEC_MISALIGN_TRAP_EN
    ,
    .trap_o        (trap_o),
    .trap_pc_o     (trap_pc_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge and settle just past it; checks and new stimulus follow.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one valid instruction on the ID/EX inputs.
  task automatic drive(input logic [31:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [5:0] op, input logic s1, input logic s2, input logic rw);
    valid_i       = 1'b1;
    pc_i          = pc;
    instruction_i = {17'b0, f3, 5'b0, opc};
    rs1_i         = rs1;
    rs2_i         = rs2;
    rd_i          = rd;
    rs1_data_i    = d1;
    rs2_data_i    = d2;
    imm_i         = imm;
    aluop_i       = op;
    alusrc1_i     = s1;
    alusrc2_i     = s2;
    reg_write_i   = rw;
    is_load_i     = 1'b0;
    is_store_i    = 1'b0;
    wb_we_i       = 1'b0;
    wb_rd_i       = '0;
    wb_data_i     = '0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    wb_we_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    mem_ready_i = 1'b1;
    drive(32'h0, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 6'd0, 1'b0, 1'b0, 1'b0);
    idle();
    step();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL reset_pc_select got %b exp 0", pc_select_o); end
    checks++; if (pc_new_o !== RESET_PC) begin errors++; $display("FAIL reset_pc_new got %h exp %h", pc_new_o, RESET_PC); end
    checks++; if (alu_result_o !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 0", alu_result_o); end
    checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b exp 0", reg_write_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_add();
    drive(32'h0, OP_ALU, 3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", valid_o); end
    checks++; if (alu_result_o !== 32'd12) begin errors++; $display("FAIL add_result got %0d exp 12", alu_result_o); end
    checks++; if (rd_o !== 5'd3) begin errors++; $display("FAIL add_rd got %0d exp 3", rd_o); end
    checks++; if (reg_write_o !== 1'b1) begin errors++; $display("FAIL add_reg_write got %b exp 1", reg_write_o); end
  endtask

  // Runs right after test_add, with ADD x3 = 12 sitting in EX/MEM.
  task automatic test_back_to_back();
    // SUB x4 = x3 - x1, x3 forwarded from EX/MEM over stale register data.
    drive(32'h4, OP_ALU, 3'd0, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 0, 6'd1, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (alu_result_o !== 32'd7) begin errors++; $display("FAIL fwd_exmem got %0d exp 7", alu_result_o); end
    // EX/MEM now holds x4; x3 only matches the WB source.
    drive(32'h8, OP_ALU, 3'd0, 5'd3, 5'd1, 5'd5, 32'd0, 32'd5, 0, 6'd1, 1'b0, 1'b0, 1'b1);
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'd20;
    step();
    checks++; if (alu_result_o !== 32'd15) begin errors++; $display("FAIL fwd_wb got %0d exp 15", alu_result_o); end
    // Both sources match x5: EX/MEM (15) wins over WB (99); 15 + 1 = 16.
    drive(32'hC, OP_ALU, 3'd0, 5'd5, 5'd0, 5'd6, 32'd0, 32'd1, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'd99;
    step();
    checks++; if (alu_result_o !== 32'd16) begin errors++; $display("FAIL fwd_priority got %0d exp 16", alu_result_o); end
    // A load in EX/MEM writing x7 is not a forward source.
    drive(32'h10, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd7, 32'd100, 32'd0, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    is_load_i = 1'b1;
    step();
    checks++; if (is_load_o !== 1'b1) begin errors++; $display("FAIL load_flag got %b exp 1", is_load_o); end
    drive(32'h14, OP_ALU, 3'd0, 5'd7, 5'd0, 5'd8, 32'd50, 32'd0, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (alu_result_o !== 32'd50) begin errors++; $display("FAIL no_fwd_load got %0d exp 50", alu_result_o); end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  // rd and rs are x0 throughout, so no vector can forward into the next.
  task automatic test_alu();
    alu_vec_t v[11];
    v[0]  = '{6'd0, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000};
    v[1]  = '{6'd1, 32'd3,         32'd5,        32'hFFFF_FFFE};
    v[2]  = '{6'd2, 32'd1,         32'd33,       32'h0000_0002};
    v[3]  = '{6'd3, 32'hFFFF_FFFF, 32'd1,        32'h0000_0001};
    v[4]  = '{6'd4, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000};
    v[5]  = '{6'd5, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00};
    v[6]  = '{6'd6, 32'h8000_0000, 32'd4,        32'h0800_0000};
    v[7]  = '{6'd7, 32'h8000_0000, 32'd4,        32'hF800_0000};
    v[8]  = '{6'd8, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F};
    v[9]  = '{6'd9, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F};
    v[10] = '{6'd10, 32'd5,        32'd5,        32'h0000_0000};
    // x0 sources with nonzero EX/MEM results must still read raw data.
    for (int i = 0; i < 11; i++) begin
      drive(32'h0, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd0, v[i].a, v[i].b, 0, v[i].op, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (alu_result_o !== v[i].exp) begin
        errors++; $display("FAIL alu_op%0d got %h exp %h", v[i].op, alu_result_o, v[i].exp);
      end
    end
    // op1 = pc, op2 = imm.
    drive(32'h1000, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd0, 32'd7, 32'd9, 32'h10, 6'd0, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if (alu_result_o !== 32'h1010) begin errors++; $display("FAIL alu_srcsel got %h exp 1010", alu_result_o); end
  endtask

  task automatic test_branch();
    drive(32'h100, OP_BR, 3'b000, 5'd6, 5'd7, 5'd0, 32'd9, 32'd9, 32'h20, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b1) begin errors++; $display("FAIL beq_select got %b exp 1", pc_select_o); end
    checks++; if (pc_new_o !== 32'h120) begin errors++; $display("FAIL beq_target got %h exp 120", pc_new_o); end
    checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL beq_no_write got %b exp 0", reg_write_o); end
    // Wrong-path instruction: squashed.
    drive(32'h104, OP_ALU, 3'd0, 5'd1, 5'd1, 5'd8, 32'd1, 32'd1, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL shadow_valid got %b exp 0", valid_o); end
    checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL shadow_write got %b exp 0", reg_write_o); end
    checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL select_pulse got %b exp 0", pc_select_o); end
    // BNE with equal operands: not taken, target held.
    drive(32'h200, OP_BR, 3'b001, 5'd6, 5'd7, 5'd0, 32'd9, 32'd9, 32'h40, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b0 || pc_new_o !== 32'h120) begin errors++; $display("FAIL bne_not_taken got %b/%h exp 0/120", pc_select_o, pc_new_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bne_valid got %b exp 1", valid_o); end
    // funct3 010 is never taken, even with equal operands.
    drive(32'h204, OP_BR, 3'b010, 5'd6, 5'd7, 5'd0, 32'd9, 32'd9, 32'h40, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL f3_010 got %b exp 0", pc_select_o); end
    // BLT signed: -1 < 1 taken.
    drive(32'h300, OP_BR, 3'b100, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h8, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b1 || pc_new_o !== 32'h308) begin errors++; $display("FAIL blt got %b/%h exp 1/308", pc_select_o, pc_new_o); end
    idle();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", valid_o); end
    // BGEU: 1 >= 0xFFFFFFFF unsigned is false.
    drive(32'h400, OP_BR, 3'b111, 5'd6, 5'd7, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'h8, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b0 || pc_new_o !== 32'h308) begin errors++; $display("FAIL bgeu got %b/%h exp 0/308", pc_select_o, pc_new_o); end
    // BLTU taken with a negative offset.
    drive(32'h500, OP_BR, 3'b110, 5'd6, 5'd7, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b1 || pc_new_o !== 32'h4F0) begin errors++; $display("FAIL bltu got %b/%h exp 1/4f0", pc_select_o, pc_new_o); end
    idle();
    step();
  endtask

  task automatic test_jump();
    drive(32'h80, OP_JAL, 3'd0, 5'd0, 5'd0, 5'd1, 0, 0, 32'h10, 6'd0, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if (pc_select_o !== 1'b1 || pc_new_o !== 32'h90) begin errors++; $display("FAIL jal_target got %b/%h exp 1/90", pc_select_o, pc_new_o); end
    checks++; if (alu_result_o !== 32'h84) begin errors++; $display("FAIL jal_link got %h exp 84", alu_result_o); end
    idle();
    step();
    drive(32'h40, OP_JR, 3'd0, 5'd9, 5'd0, 5'd1, 32'h1003, 0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b1);
    step();
    checks++; if (alu_result_o !== 32'h44) begin errors++; $display("FAIL jalr_link got %h exp 44", alu_result_o); end
`ifdef EXEC_MISALIGN_TRAP_EN
    checks++; if (trap_o !== 1'b1 || trap_pc_o !== 32'h40) begin errors++; $display("FAIL jalr_trap got %b/%h exp 1/40", trap_o, trap_pc_o); end
    checks++; if (pc_select_o !== 1'b0 || pc_new_o !== 32'h90) begin errors++; $display("FAIL jalr_no_redirect got %b/%h exp 0/90", pc_select_o, pc_new_o); end
    checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL jalr_trap_write got %b exp 0", reg_write_o); end
`else
    checks++; if (pc_select_o !== 1'b1 || pc_new_o !== 32'h1002) begin errors++; $display("FAIL jalr_target got %b/%h exp 1/1002", pc_select_o, pc_new_o); end
    checks++; if (reg_write_o !== 1'b1) begin errors++; $display("FAIL jalr_write got %b exp 1", reg_write_o); end
`endif
    idle();
    step();
    checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL jalr_pulse got %b exp 0", pc_select_o); end
  endtask

  task automatic test_stall();
    drive(32'h0, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd3, 32'd1, 32'd2, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (valid_o !== 1'b1 || alu_result_o !== 32'd3) begin errors++; $display("FAIL stall_first got %b/%0d exp 1/3", valid_o, alu_result_o); end
    mem_ready_i = 1'b0;
    drive(32'h4, OP_ALU, 3'd0, 5'd0, 5'd0, 5'd4, 32'd10, 32'd20, 0, 6'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b exp 0", i, ready_o); end
      checks++; if (alu_result_o !== 32'd3 || rd_o !== 5'd3 || valid_o !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got %0d/%0d/%b exp 3/3/1", i, alu_result_o, rd_o, valid_o);
      end
      checks++; if (store_data_o !== 32'd2) begin errors++; $display("FAIL stall_store%0d got %0d exp 2", i, store_data_o); end
    end
    mem_ready_i = 1'b1;
    step();
    checks++; if (alu_result_o !== 32'd30 || rd_o !== 5'd4) begin errors++; $display("FAIL stall_release got %0d/%0d exp 30/4", alu_result_o, rd_o); end
    idle();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    drive(32'h600, OP_BR, 3'b000, 5'd6, 5'd7, 5'd0, 32'd4, 32'd4, 32'h10, 6'd0, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (pc_select_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset got %b/%b exp 1/1", pc_select_o, valid_o); end
    reset_i = 1'b1;
    idle();
    step();
    checks++; if (valid_o !== 1'b0 || pc_select_o !== 1'b0) begin errors++; $display("FAIL midreset_ctl got %b/%b exp 0/0", valid_o, pc_select_o); end
    checks++; if (pc_new_o !== RESET_PC) begin errors++; $display("FAIL midreset_pc got %h exp %h", pc_new_o, RESET_PC); end
    checks++; if (alu_result_o !== 32'h0 || store_data_o !== 32'h0 || rd_o !== 5'd0) begin
      errors++; $display("FAIL midreset_data got %h/%h/%0d exp 0/0/0", alu_result_o, store_data_o, rd_o);
    end
    reset_i = 1'b0;
    step();
    checks++; if (pc_select_o !== 1'b0) begin errors++; $display("FAIL post_reset_select got %b exp 0", pc_select_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
